// File: rtl/rx232_resp.sv
// rx232_resp: serial command responder.
// Collects a 4-byte command frame (SYNC_RX, cmd, arg, xor) from rx232_pd,
// validates it, and answers through tx232 with a 4-byte response frame
// (SYNC_TX, cmd, status, xor), one byte per tstart, GAP txck ticks apart.
module rx232_resp #(
   parameter logic [7:0] SYNC_RX = 8'hA5,
   parameter logic [7:0] SYNC_TX = 8'h5A,
   parameter int         GAP     = 11,
   parameter int         TMO     = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       txck,
   input  logic       rxen,
   input  logic       rnpd,
   input  logic [7:0] rxpd,
   output logic       tstart,
   output logic [7:0] txpd,
   output logic       busy,
   output logic       frm_ok,
   output logic       frm_err,
   output logic [7:0] rcmd,
   output logic [7:0] rarg
);

   localparam int GW = $clog2(GAP + 1);
   localparam int TW = $clog2(TMO + 1);

   localparam logic [1:0] S_HUNT    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_CHECK   = 2'd2;
   localparam logic [1:0] S_RESP    = 2'd3;

   logic [1:0]    state;
   logic [1:0]    idx;
   logic [TW-1:0] tmo_cnt;
   logic [TW-1:0] tmo_nxt;
   logic [GW-1:0] gap_cnt;
   logic          last_gap;
   logic [7:0]    fb [0:3];
   logic          sum_ok;
   logic [7:0]    rsp_cmd;
   logic [7:0]    rsp_stat;
   logic [1:0]    tx_sel;
   logic [1:0]    fire_sel;
   logic          sent;
   logic          tx_live;
   logic          fire;

   // Byte sel of the response frame; the last byte is the running xor.
   function automatic logic [7:0] resp_byte(input logic [1:0] sel,
                                            input logic [7:0] c,
                                            input logic [7:0] s);
      logic [7:0] r;
      case (sel)
         2'd0:    r = SYNC_TX;
         2'd1:    r = c;
         2'd2:    r = s;
         default: r = SYNC_TX ^ c ^ s;
      endcase
      return r;
   endfunction

   // Transmit handshake and status decode; tstart coincides with the txck tick.
   always_comb begin
      last_gap = (gap_cnt == GW'(GAP - 1));
      fire     = (state == S_RESP) && txck &&
                 (!sent || (last_gap && (tx_sel != 2'd3)));
      fire_sel = sent ? (tx_sel + 2'd1) : 2'd0;
      tstart   = fire;
      // The byte for a new tstart must be on txpd in that same cycle.
      txpd     = tx_live ? resp_byte(fire ? fire_sel : tx_sel, rsp_cmd, rsp_stat)
                         : 8'h00;
      busy     = (state == S_CHECK) || (state == S_RESP);
      // Inter-byte timer: an rxen clears it, a txck in the same cycle still counts.
      tmo_nxt  = (rxen ? '0 : tmo_cnt) + TW'(txck);
      sum_ok   = ((fb[0] ^ fb[1] ^ fb[2]) == fb[3]);
   end

   // Frame state machine, counters and the latched command outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_HUNT;
         idx     <= 2'd0;
         tmo_cnt <= '0;
         gap_cnt <= '0;
         tx_sel  <= 2'd0;
         sent    <= 1'b0;
         tx_live <= 1'b0;
         frm_ok  <= 1'b0;
         frm_err <= 1'b0;
         rcmd    <= 8'h00;
         rarg    <= 8'h00;
      end else begin
         frm_ok  <= 1'b0;
         frm_err <= 1'b0;
         case (state)
            S_HUNT: begin
               if (rxen && !rnpd && (rxpd == SYNC_RX)) begin
                  state   <= S_COLLECT;
                  idx     <= 2'd1;
                  tmo_cnt <= TW'(txck);
               end
            end
            S_COLLECT: begin
               if (rxen) begin
                  tmo_cnt <= tmo_nxt;
                  if (rnpd) begin
                     // Framing error answers at once, without the rest of the frame.
                     state   <= S_RESP;
                     frm_err <= 1'b1;
                     idx     <= 2'd0;
                     tmo_cnt <= '0;
                     tx_sel  <= 2'd0;
                     sent    <= 1'b0;
                     gap_cnt <= '0;
                     tx_live <= 1'b1;
                  end else if (idx == 2'd3) begin
                     state   <= S_CHECK;
                     idx     <= 2'd0;
                     tmo_cnt <= '0;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end else if (tmo_nxt == TW'(TMO)) begin
                  // Sender went quiet mid-frame: drop it without answering.
                  state   <= S_HUNT;
                  idx     <= 2'd0;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_nxt;
               end
            end
            S_CHECK: begin
               frm_ok  <= sum_ok;
               frm_err <= !sum_ok;
               if (sum_ok) begin
                  rcmd <= fb[1];
                  rarg <= fb[2];
               end
               state   <= S_RESP;
               tx_sel  <= 2'd0;
               sent    <= 1'b0;
               gap_cnt <= '0;
               tx_live <= 1'b1;
            end
            S_RESP: begin
               if (txck) begin
                  if (!sent) begin
                     sent    <= 1'b1;
                     gap_cnt <= '0;
                  end else if (last_gap) begin
                     gap_cnt <= '0;
                     if (tx_sel == 2'd3) begin
                        // Guard time after R3 has run out; tx_sel stays so txpd holds R3.
                        state <= S_HUNT;
                        sent  <= 1'b0;
                     end else begin
                        tx_sel <= tx_sel + 2'd1;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + GW'(1);
                  end
               end
            end
            default: state <= S_HUNT;
         endcase
      end
   end

   // Frame byte store and response contents (data only, no reset needed).
   always_ff @(posedge clk) begin
      if (rxen && (state == S_HUNT))
         fb[0] <= rxpd;
      if (rxen && (state == S_COLLECT))
         fb[idx] <= rxpd;
      if (rxen && rnpd && (state == S_COLLECT)) begin
         rsp_cmd  <= 8'h00;
         rsp_stat <= 8'h02;
      end else if (state == S_CHECK) begin
         rsp_cmd  <= fb[1];
         rsp_stat <= sum_ok ? 8'h00 : 8'h01;
      end
   end

endmodule

// File: doc/rx232_resp.md
Name: rx232_resp

Overview:
- Command responder on the serial link, sitting between rx232_pd (byte receive side) and tx232 (byte transmit side).
- Hunts for and collects a 4-byte command frame from the received byte stream, checks it, and latches the command.
- Drives tx232 byte-by-byte (tstart/txpd) with a 4-byte response frame carrying a status code.
- Replaces tx232_ctl as tx232's driver on boards that answer a host instead of originating traffic.

Parameters:
- SYNC_RX, 8'hA5, required first byte of a command frame
- SYNC_TX, 8'h5A, first byte of every response frame
- GAP, 11, txck ticks from one tstart to the next (start + 8 data + stop + 1 guard)
- TMO, 32, txck ticks allowed between received bytes inside a frame before the frame is discarded

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- txck  in  1  bit-rate tick enable, one clk wide
- rxen  in  1  one-clk strobe: rxpd/rnpd valid
- rnpd  in  1  framing error on the byte strobed by rxen (stop bit low)
- rxpd  in  8  received byte
- tstart  out  1  one-clk pulse to tx232: send txpd
- txpd  out  8  byte for tx232; held stable from its tstart until the next tstart
- busy  out  1  high from the end of frame collection until the last response byte's GAP expires
- frm_ok  out  1  one-clk pulse: valid command latched
- frm_err  out  1  one-clk pulse: checksum or framing error detected
- rcmd  out  8  last valid command byte
- rarg  out  8  last valid argument byte

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all outputs are 0, state HUNT, all counters 0. Asserting rst mid-frame or mid-response aborts immediately; tstart is 0 from the next edge.
- Command frame: B0 = SYNC_RX, B1 = cmd, B2 = arg, B3 = B0 ^ B1 ^ B2.
- Response frame: R0 = SYNC_TX, R1 = cmd, R2 = status, R3 = R0 ^ R1 ^ R2.
  - status 00 = ok, 01 = checksum error, 02 = framing error.
  - On a framing error, R1 = 00.

States:
- HUNT
  - On rxen with rnpd = 0 and rxpd = SYNC_RX: store B0, go to COLLECT with idx = 1.
  - Any other byte (including any byte with rnpd = 1) is dropped silently.
- COLLECT
  - On each rxen: store the byte at idx, then increment idx.
  - On rxen with rnpd = 1: go to RESP with status 02 and pulse frm_err.
  - After B3 is stored: go to CHECK.
  - Inter-byte timer: cleared on every rxen, incremented on every txck. When it reaches TMO, return to HUNT with no response.
- CHECK (exactly 1 clk)
  - Checksum match: latch rcmd/rarg, pulse frm_ok, status 00.
  - Checksum mismatch: pulse frm_err, status 01; rcmd/rarg are not updated.
  - Go to RESP.
- RESP
  - Load R0 onto txpd. Pulse tstart on the first clk with txck = 1.
  - Gap counter clears at each tstart and counts txck ticks. When it reaches GAP, load the next byte and pulse tstart on that same txck cycle.
  - After R3's tstart, wait GAP ticks, then go to HUNT.

Timing and boundary rules:
- Latency: rxen of B3 at cycle N → CHECK at N+1 → R0 tstart at the first clk ≥ N+2 with txck = 1.
- busy is high in CHECK and RESP.
- rxen while busy is ignored: no state change, no flags.
- rxen and txck in the same cycle are both honoured.
- idx is 2 bits and never wraps past 3 within a frame.
- All XOR arithmetic is 8-bit.

Test Plan:
- Good frame A5 10 3C 89 → frm_ok pulse, rcmd = 10, rarg = 3C; tstart ×4 with txpd 5A 10 00 4A, each tstart exactly 11 txck ticks apart.
- Bad checksum A5 10 3C 88 → frm_err pulse, rcmd/rarg unchanged; response 5A 10 01 4B.
- A5 then a byte with rnpd = 1 → frm_err; response 5A 00 02 58 starts without waiting for further bytes.
- Hunt: 00 FF A5 20 00 85 → first two bytes dropped, frm_ok, response 5A 20 00 7A.
- Timeout: A5, then 32 txck ticks idle, then 10 3C 89 → no response, no flags, state HUNT.
- Bytes injected during a response are ignored, and the response is unchanged. Separately: rst asserted after the second tstart → tstart is 0 from the next clk, all outputs are 0, and a following good frame is answered normally.
